// File: rtl/ifetch_prefetch_pkg.sv
// Shared definitions for the instruction fetch / prefetch stage.
package ifetch_prefetch_pkg;

    // Default width of the word-addressed fetch PC.
    localparam int PC_W_DEF = 6;

    // Canonical RISC-V NOP (addi x0, x0, 0), available to fetch consumers.
    localparam logic [31:0] NOP = 32'h0000_0013;

    // One buffered fetch result at the default PC width.
    typedef struct packed {
        logic [PC_W_DEF-1:0] pc;
        logic [31:0]         instr;
    } fetch_entry_t;

    // RUN: responses are kept. DRAIN: responses issued before a redirect
    // are still returning and are discarded.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/ifetch_prefetch_sync_fifo.sv
// Synchronous FIFO with flush, registered occupancy count and
// combinational head read. A push into a full FIFO is accepted only when a
// pop happens in the same cycle; a pop of an empty FIFO is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Handshake qualification and head/status decode.
    always_comb begin
        full     = (count == CW'(DEPTH));
        empty    = (count == '0);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        pop_data = mem[rd_ptr];
    end

    // Pointer and occupancy update; flush empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents are don't-care until counted as valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction fetch with prefetch buffer. Issues word reads to instruction
// memory, tags each in-flight request with its PC, buffers returned words
// and hands them to decode over valid/ready. Redirects flush the buffer
// and discard responses still in flight from the old path.
module ifetch_prefetch
    import ifetch_prefetch_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int DEPTH     = 4,
    parameter int MAX_OUTST = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_valid,
    input  logic [PC_W-1:0]        redirect_pc,
    output logic                   imem_req,
    output logic [PC_W-1:0]        imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [31:0]            imem_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instr,
    output logic [PC_W-1:0]        out_pc,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTST) + 1;
    localparam int SW = CW + OW;

    fetch_state_t      state;
    logic [PC_W-1:0]   fetch_pc;
    logic [OW-1:0]     outstanding;
    logic [OW-1:0]     drop_cnt;
    logic [OW-1:0]     drop_next;
    logic [SW-1:0]     credit_used;

    logic [PC_W-1:0]   tag_pc;
    logic              tag_empty;
    logic [PC_W+31:0]  pf_head;
    logic              pf_empty;

    logic              issue;
    logic              resp;
    logic              keep;
    logic              pop;

    // Request credit: buffered + in flight, minus responses that will be
    // discarded, must leave room for every kept response.
    always_comb begin
        credit_used = SW'(fifo_count) + SW'(outstanding) - SW'(drop_cnt);
        imem_req    = !rst && !redirect_valid
                      && (outstanding < OW'(MAX_OUTST))
                      && (credit_used < SW'(DEPTH));
        imem_addr   = fetch_pc;
        issue       = imem_req && imem_gnt;
        resp        = imem_rvalid && !tag_empty;
        keep        = resp && (state == ST_RUN) && !redirect_valid;
        pop         = out_valid && out_ready;
    end

    // Next drop count: a redirect marks everything still in flight after
    // this cycle's response as stale; otherwise each stale response retires one.
    always_comb begin
        drop_next = drop_cnt;
        if (redirect_valid)
            drop_next = outstanding - OW'(resp);
        else if (resp && (state == ST_DRAIN))
            drop_next = drop_cnt - OW'(1);
    end

    // Fetch PC, drop counter and RUN/DRAIN state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= '0;
            drop_cnt <= '0;
            state    <= ST_RUN;
        end else begin
            if (redirect_valid)
                fetch_pc <= redirect_pc;
            else if (issue)
                fetch_pc <= fetch_pc + PC_W'(1);
            drop_cnt <= drop_next;
            state    <= (drop_next != '0) ? ST_DRAIN : ST_RUN;
        end
    end

    // Tag FIFO: PCs of issued requests in issue order; its occupancy is the
    // outstanding-request count. Stale tags retire with their dropped data.
    sync_fifo #(
        .WIDTH (PC_W),
        .DEPTH (MAX_OUTST)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (issue),
        .push_data (fetch_pc),
        .pop       (resp),
        .pop_data  (tag_pc),
        .empty     (tag_empty),
        .count     (outstanding)
    );

    // Prefetch FIFO: {pc, instr} entries presented to decode.
    sync_fifo #(
        .WIDTH (PC_W + 32),
        .DEPTH (DEPTH)
    ) u_prefetch_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (keep),
        .push_data ({tag_pc, imem_rdata}),
        .pop       (pop),
        .pop_data  (pf_head),
        .empty     (pf_empty),
        .count     (fifo_count)
    );

    // Head presentation; payload reads as zero while the buffer is empty.
    always_comb begin
        out_valid = !pf_empty;
        out_pc    = out_valid ? pf_head[PC_W+31:32] : '0;
        out_instr = out_valid ? pf_head[31:0]       : '0;
    end

endmodule
